stream_host: RTL and testbench

STREAM_HOST -- requirements
Module: stream_host

---
 rtl/stream_host.sv | 186 ++++++++++++++++++
 tb/tb_stream_host.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_host.sv
// stream_host: command-driven host that streams source memory words to an
// accelerator (parameter loads and batch runs) and writes the returned
// result words into a result memory.
// Optional feature: define STREAM_HOST_STALL_CNT_EN to add the 16-bit
// stall_cnt output counting SRC cycles where a word waits on src_ready.
module stream_host #(
    parameter int DW      = 32,
    parameter int SRC_LEN = 16,
    parameter int DST_LEN = 8,
    parameter int PRM_LEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_matw,
    input  logic [7:0]    cmd_nbatch,
    output logic          mem_re,
    output logic [11:0]   mem_a,
    input  logic [DW-1:0] mem_rd,
    output logic          run,
    output logic          matw,
    output logic          last,
    output logic          src_valid,
    input  logic          src_ready,
    output logic [DW-1:0] src_data,
    input  logic          dst_valid,
    output logic          dst_ready,
    input  logic [DW-1:0] dst_data,
    output logic          res_we,
    output logic [11:0]   res_a,
    output logic [DW-1:0] res_wd,
    output logic          done
`ifdef STREAM_HOST_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, PRM, SRC, DRAIN, FIN} state_t;

    state_t        state, state_nxt;
    logic [11:0]   ra, wa;
    logic [15:0]   word_total, last_start, dst_total;
    logic [15:0]   rd_cnt, tx_cnt, dst_cnt, dst_cnt_nxt;
    logic [15:0]   cmd_words, cmd_dst;
    logic [7:0]    nb_eff;
    logic [DW-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
    logic [1:0]    buf_cnt, buf_cnt_nxt, occ;
    logic          rd_pend;
    logic          run_q, matw_q, last_q, done_q, cmd_ready_q, dst_ready_q;
    logic          accept, streaming, issue, xfer, tx_final, dst_acc;

    // Command decode, read issue, output buffer next value and next state
    always_comb begin
        nb_eff      = (cmd_nbatch == 8'd0) ? 8'd1 : cmd_nbatch;
        cmd_words   = cmd_matw ? 16'(PRM_LEN) : 16'(nb_eff) * 16'(SRC_LEN);
        cmd_dst     = 16'(nb_eff) * 16'(DST_LEN);
        accept      = (state == IDLE) && cmd_valid;
        streaming   = (state == PRM) || (state == SRC);
        occ         = buf_cnt + {1'b0, rd_pend};
        issue       = streaming && (rd_cnt != word_total) && (occ < 2'd2);
        xfer        = (buf_cnt != 2'd0) &&
                      ((state == PRM) || ((state == SRC) && src_ready));
        tx_final    = xfer && (tx_cnt == word_total - 16'd1);
        dst_acc     = dst_valid && dst_ready_q;
        dst_cnt_nxt = dst_cnt + {15'd0, dst_acc};

        // Pop shifts entry 1 to the head; returning read data lands in the
        // first free slot after the pop.
        buf0_nxt    = buf0;
        buf1_nxt    = buf1;
        buf_cnt_nxt = buf_cnt;
        if (xfer) begin
            buf0_nxt    = buf1;
            buf_cnt_nxt = buf_cnt - 2'd1;
        end
        if (rd_pend) begin
            if (buf_cnt_nxt == 2'd0) buf0_nxt = mem_rd;
            else                     buf1_nxt = mem_rd;
            buf_cnt_nxt = buf_cnt_nxt + 2'd1;
        end

        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_matw ? PRM : SRC;
            PRM:     if (tx_final) state_nxt = FIN;
            SRC:     if (tx_final) state_nxt = DRAIN;
            DRAIN:   if (dst_cnt_nxt >= dst_total) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ra          <= '0;
            wa          <= '0;
            rd_cnt      <= '0;
            tx_cnt      <= '0;
            dst_cnt     <= '0;
            word_total  <= '0;
            last_start  <= '0;
            dst_total   <= '0;
            buf_cnt     <= '0;
            rd_pend     <= 1'b0;
            run_q       <= 1'b0;
            matw_q      <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            dst_ready_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == IDLE);
            matw_q      <= (state_nxt == PRM);
            run_q       <= (state_nxt == SRC) || (state_nxt == DRAIN);
            dst_ready_q <= (state_nxt == SRC) || (state_nxt == DRAIN);
            done_q      <= (state_nxt == FIN);
            rd_pend     <= issue;
            buf_cnt     <= buf_cnt_nxt;
            if (accept) begin
                ra         <= '0;
                wa         <= '0;
                rd_cnt     <= '0;
                tx_cnt     <= '0;
                dst_cnt    <= '0;
                word_total <= cmd_words;
                dst_total  <= cmd_matw ? '0 : cmd_dst;
                last_start <= cmd_matw ? '0 : cmd_words - 16'(SRC_LEN);
                last_q     <= !cmd_matw && (nb_eff == 8'd1);
            end else begin
                if (issue) begin
                    ra     <= ra + 12'd1;
                    rd_cnt <= rd_cnt + 16'd1;
                end
                if (xfer) begin
                    tx_cnt <= tx_cnt + 16'd1;
                    // last goes high for the word that opens the final batch
                    if ((state == SRC) && (tx_cnt + 16'd1 == last_start))
                        last_q <= 1'b1;
                end
                if (dst_acc) begin
                    wa      <= wa + 12'd1;
                    dst_cnt <= dst_cnt_nxt;
                end
                if (state_nxt == FIN) last_q <= 1'b0;
            end
        end
    end

    // Output buffer data (occupancy is tracked by buf_cnt)
    always_ff @(posedge clk) begin
        buf0 <= buf0_nxt;
        buf1 <= buf1_nxt;
    end

`ifdef STREAM_HOST_STALL_CNT_EN
    // Saturating count of SRC cycles with a word held by backpressure
    always_ff @(posedge clk) begin
        if (reset || accept)
            stall_cnt <= '0;
        else if ((state == SRC) && (buf_cnt != 2'd0) && !src_ready &&
                 (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    // Reset forces the idle values onto the ports in the reset cycle itself
    assign cmd_ready = cmd_ready_q | reset;
    assign run       = run_q & ~reset;
    assign matw      = matw_q & ~reset;
    assign last      = last_q & ~reset;
    assign done      = done_q & ~reset;
    assign dst_ready = dst_ready_q & ~reset;
    assign mem_re    = issue & ~reset;
    assign mem_a     = reset ? '0 : ra;
    assign src_valid = (buf_cnt != 2'd0) & ~reset;
    assign src_data  = buf0;
    assign res_we    = dst_acc & ~reset;
    assign res_a     = reset ? '0 : wa;
    assign res_wd    = dst_data;

endmodule

// File: tb/tb_stream_host.sv
// Bench for stream_host: memory model, accelerator result driver and
// scoreboards for the source stream and the result writes.
module tb_stream_host;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          run;
        logic          matw;
    } src_t;

    typedef struct packed {
        logic [11:0]   a;
        logic [DW-1:0] d;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_matw = 1'b0;
    logic [7:0]    cmd_nbatch = 8'd0;
    logic          mem_re;
    logic [11:0]   mem_a;
    logic [DW-1:0] mem_rd = '0;
    logic          run, matw, last;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic [DW-1:0] src_data;
    logic          dst_valid = 1'b0;
    logic          dst_ready;
    logic [DW-1:0] dst_data = '0;
    logic          res_we;
    logic [11:0]   res_a;
    logic [DW-1:0] res_wd;
    logic          done;
`ifdef STREAM_HOST_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    stream_host #(.DW(DW), .SRC_LEN(16), .DST_LEN(8), .PRM_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_matw(cmd_matw), .cmd_nbatch(cmd_nbatch),
        .mem_re(mem_re), .mem_a(mem_a), .mem_rd(mem_rd),
        .run(run), .matw(matw), .last(last),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .res_we(res_we), .res_a(res_a), .res_wd(res_wd),
        .done(done)
`ifdef STREAM_HOST_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    src_t          src_exp[$];
    res_t          res_exp[$];
    logic [DW-1:0] dst_q[$];

    int   xfer_cnt = 0;
    int   done_cnt = 0;
    int   stall_exp = 0;
    int   dst_sent = 0;
    int   dst_rel = 0;
    int   dst_mode = 0;
    int   rdy_mode = 0;
    int   cyc = 0;
    logic dst_force = 1'b0;
    logic dst_hs = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] memval(input logic [11:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Source memory with one cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rd <= memval(mem_a);
    end

    // Monitor: sampled at negedge, values hold through the next rising edge
    always @(negedge clk) begin
        src_t e;
        res_t r;
        if (!reset) begin
            if (src_valid && (matw || src_ready)) begin
                if (src_exp.size() == 0) begin
                    check("src_extra", 64'(src_exp.size()), 64'd1);
                end else begin
                    e = src_exp.pop_front();
                    check("src_data", 64'(src_data), 64'(e.data));
                    check("src_ctl", 64'({last, run, matw}), 64'({e.last, e.run, e.matw}));
                end
                if (run) begin
                    xfer_cnt++;
                    if (dst_mode == 0 && (xfer_cnt % 16) == 0) dst_rel += 8;
                end
            end else if (run && src_valid && src_exp.size() > 0) begin
                check("src_hold", 64'(src_data), 64'(src_exp[0].data));
            end
            if (run && src_valid && !src_ready) stall_exp++;
            if (res_we) begin
                if (res_exp.size() == 0) begin
                    check("res_extra", 64'(res_exp.size()), 64'd1);
                end else begin
                    r = res_exp.pop_front();
                    check("res_a", 64'(res_a), 64'(r.a));
                    check("res_wd", 64'(res_wd), 64'(r.d));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_ctl", 64'({run, cmd_ready}), 64'd0);
            end
            dst_hs = dst_valid && dst_ready;
        end else begin
            dst_hs = 1'b0;
        end
    end

    // Accelerator-side driver: result words and src_ready pattern
    always @(posedge clk) begin
        #1;
        if (dst_hs && dst_q.size() > 0) begin
            void'(dst_q.pop_front());
            dst_sent++;
        end
        dst_valid = (dst_q.size() > 0) && (dst_force || dst_sent < dst_rel);
        dst_data  = (dst_q.size() > 0) ? dst_q[0] : '0;
        src_ready = (rdy_mode != 0) ? rdy_pat[cyc % 4] : 1'b1;
        cyc++;
    end

    task automatic prep(input logic m, input int nb, input int early, input int rmode);
        int nbe;
        logic [DW-1:0] d;
        nbe = (nb == 0) ? 1 : nb;
        xfer_cnt  = 0;
        stall_exp = 0;
        dst_sent  = 0;
        dst_mode  = early;
        rdy_mode  = rmode;
        if (m) begin
            for (int i = 0; i < 32; i++)
                src_exp.push_back('{memval(12'(i)), 1'b0, 1'b0, 1'b1});
            dst_rel = 0;
        end else begin
            for (int i = 0; i < nbe * 16; i++)
                src_exp.push_back('{memval(12'(i)), (i >= (nbe - 1) * 16), 1'b1, 1'b0});
            for (int j = 0; j < nbe * 8; j++) begin
                d = $urandom;
                dst_q.push_back(d);
                res_exp.push_back('{12'(j), d});
            end
            dst_rel = early ? nbe * 8 : 0;
        end
    endtask

    task automatic issue(input logic m, input int nb);
        @(negedge clk);
        #2;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_matw   = m;
        cmd_nbatch = 8'(nb);
        cmd_valid  = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic m, input int nb,
                           input int early, input int rmode);
        int d0;
        prep(m, nb, early, rmode);
        d0 = done_cnt;
        issue(m, nb);
        for (int c = 0; c < 4000 && done_cnt == d0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_src_left"}, 64'(src_exp.size()), 64'd0);
        check({tag, "_res_left"}, 64'(res_exp.size()), 64'd0);
`ifdef STREAM_HOST_STALL_CNT_EN
        if (!m) check({tag, "_stall"}, 64'(stall_cnt), 64'(stall_exp));
`endif
        src_exp.delete();
        res_exp.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        // Reset values, during and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_ctl", 64'({run, matw, last, src_valid, mem_re, res_we, done, dst_ready, cmd_ready}), 64'd1);
        check("rst_addr", 64'({mem_a, res_a}), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("post_rst_ctl", 64'({run, matw, last, src_valid, mem_re, res_we, done, dst_ready, cmd_ready}), 64'd1);

        // Result words offered while idle or loading parameters are ignored
        dst_force = 1'b1;
        dst_q.push_back(32'hBAD0BAD0);
        repeat (3) @(negedge clk);
        #2;
        check("idle_dst_ready", 64'(dst_ready), 64'd0);
        run_cmd("prm", 1'b1, 0, 0, 0);
        dst_force = 1'b0;
        dst_q.delete();

        // Two batches, results released after each batch of source words
        run_cmd("run2", 1'b0, 2, 0, 0);

        // Backpressure pattern 1,0,0,1
        run_cmd("bp", 1'b0, 1, 0, 1);

        // Early results: all result words available from the start
        run_cmd("early", 1'b0, 3, 1, 0);

        // Reset in the middle of a batch
        prep(1'b0, 1, 0, 0);
        issue(1'b0, 1);
        for (int c = 0; c < 200 && xfer_cnt < 5; c++) @(negedge clk);
        check("mid_xfers", 64'(xfer_cnt >= 5), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("mid_rst_ctl", 64'({run, matw, last, src_valid, mem_re, res_we, done, dst_ready, cmd_ready}), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("mid_post_ctl", 64'({run, matw, last, src_valid, mem_re, res_we, done, dst_ready, cmd_ready}), 64'd1);
        check("mid_post_addr", 64'({mem_a, res_a}), 64'd0);
        src_exp.delete();
        res_exp.delete();
        dst_q.delete();
        dst_rel = 0;
        run_cmd("restart", 1'b0, 1, 0, 0);

        // nbatch=0 behaves as one batch, under backpressure
        run_cmd("nb0", 1'b0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
